regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core register file.
- Adds N combinational read ports, x0 hardwired to zero, and asynchronous clear.
- Adds write-to-read bypass and a per-register pending scoreboard, so the decode stage can detect RAW hazards against in-flight writebacks.
- Sits between decode (issue side) and writeback; exposes a debug tap of one register (a0 by default).

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
- NUM_RD, 2, number of read ports (1..4).
- DEBUG_REG, 10, index mirrored on dbg_data.
- BYPASS_EN, 1, 1 = same-cycle writeback data forwarded to read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDRESS_WIDTH  packed read addresses; port i at bits [i*AW +: AW].
- rd_use  in  NUM_RD  port i is a real source operand this cycle (qualifies hazard only).
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data.
- issue_en  in  1  instruction with destination issued this cycle.
- issue_addr  in  ADDRESS_WIDTH  destination being issued.
- wb_en  in  1  writeback enable.
- wb_addr  in  ADDRESS_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- flush  in  1  clear all pending bits (pipeline flush).
- hazard  out  1  some used source is pending and not resolved this cycle.
- pending  out  2**ADDRESS_WIDTH  scoreboard bit vector.
- dbg_data  out  DATA_WIDTH  contents of register DEBUG_REG.

Behaviour:
- Reset: rst_n low asynchronously clears all registers and all pending bits to 0. Consequently rd_data=0, dbg_data=0, pending=0, hazard=0 while in reset and after release.
- Storage write: on posedge clk, if wb_en and wb_addr!=0, regs[wb_addr] <= wb_data. Writes to x0 are discarded.
- Reads are combinational (zero latency):
  - rd_data[i] = 0 if rd_addr[i]==0.
  - Else wb_data if BYPASS_EN && wb_en && wb_addr==rd_addr[i].
  - Else regs[rd_addr[i]].
- dbg_data follows the same read rule for DEBUG_REG, bypass included.
- Scoreboard update per register r!=0, on posedge clk, in priority order:
  - flush -> 0;
  - issue_en && issue_addr==r -> 1;
  - wb_en && wb_addr==r -> 0;
  - else hold.
- Simultaneous issue and writeback to the same r: pending stays 1 (the new producer wins).
- flush beats a same-cycle issue.
- pending[0] is constant 0; issue to x0 is ignored.
- hazard (combinational) = OR over i of:
  - rd_use[i] && rd_addr[i]!=0 && pending[rd_addr[i]];
  - && !(BYPASS_EN && wb_en && wb_addr==rd_addr[i]).
- With BYPASS_EN=0, a same-cycle writeback does not clear hazard; the result becomes readable next cycle.
- Same-cycle issue_en does not affect hazard; the pending bit is visible from the next cycle.
- Writeback to a non-pending register is legal: data is written and pending is unchanged.
- Reset asserted mid-operation clears state immediately, regardless of clk.
- Implementation: a flop array with no memory inference required; all read paths are purely combinational.

Test Plan:
- Reset: write regs 1..31 with nonzero data, pulse rst_n low between edges -> all rd_data=0, pending=0, dbg_data=0 immediately.
- x0: wb_en, wb_addr=0, wb_data=0xDEADBEEF; then read addr 0 -> 0; issue_addr=0 -> pending[0] stays 0.
- Bypass: regs[5]=0x11; same cycle wb_en, wb_addr=5, wb_data=0x22, rd_addr[0]=5 -> rd_data[0]=0x22 that cycle and 0x22 the following cycle. With BYPASS_EN=0 -> 0x11 then 0x22.
- Hazard: issue_addr=7; next cycle rd_use[1]=1, rd_addr[1]=7 -> hazard=1; wb to 7 (BYPASS_EN=1) -> hazard=0 same cycle; pending[7]=0 next cycle.
- Simultaneous: register 9 pending; same cycle issue_addr=9 and wb_addr=9 -> regs[9] written, pending[9] remains 1.
- Flush: pending bits 3, 4, 8 set plus issue_addr=12 in the flush cycle -> pending=0 next cycle; hazard=0 for any read.
- Debug: wb to register 10 with 0xA5A5A5A5 -> dbg_data shows the value in the write cycle (bypass) and holds it afterwards.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with hardwired x0, writeback bypass and RAW pending scoreboard
module regfile_scoreboard #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_RD        = 2,
   parameter int DEBUG_REG     = 10,
   parameter int BYPASS_EN     = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
   input  logic [NUM_RD-1:0]               rd_use,
   output logic [NUM_RD*DATA_WIDTH-1:0]    rd_data,
   input  logic                            issue_en,
   input  logic [ADDRESS_WIDTH-1:0]        issue_addr,
   input  logic                            wb_en,
   input  logic [ADDRESS_WIDTH-1:0]        wb_addr,
   input  logic [DATA_WIDTH-1:0]           wb_data,
   input  logic                            flush,
   output logic                            hazard,
   output logic [2**ADDRESS_WIDTH-1:0]     pending,
   output logic [DATA_WIDTH-1:0]           dbg_data
);

   localparam int                       DEPTH    = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] DBG_ADDR = ADDRESS_WIDTH'(DEBUG_REG);
   localparam bit                       BYPASS   = (BYPASS_EN != 0);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      pend_q;
   logic                  wb_live;

   // a writeback only lands in storage when it targets a real register
   assign wb_live = wb_en && (wb_addr != '0);

   // true when this cycle's writeback data should be forwarded to a reader of address a
   function automatic logic fwd_hit(input logic [ADDRESS_WIDTH-1:0] a);
      return BYPASS && wb_en && (wb_addr == a);
   endfunction

   // zero for x0, forwarded writeback data on a bypass hit, otherwise the stored value
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDRESS_WIDTH-1:0] a);
      if (a == '0)
         return '0;
      if (fwd_hit(a))
         return wb_data;
      return regs[a];
   endfunction

   // storage array: x0 is never written so it keeps its reset value of zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++)
            regs[r] <= '0;
      end else if (wb_live) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // scoreboard: flush beats issue, issue beats writeback so a new producer keeps the bit set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q[0] <= 1'b0;
         for (int r = 1; r < DEPTH; r++) begin
            if (flush)
               pend_q[r] <= 1'b0;
            else if (issue_en && (issue_addr == ADDRESS_WIDTH'(r)))
               pend_q[r] <= 1'b1;
            else if (wb_en && (wb_addr == ADDRESS_WIDTH'(r)))
               pend_q[r] <= 1'b0;
         end
      end
   end

   assign pending  = pend_q;
   assign dbg_data = read_port(DBG_ADDR);

   // read ports and hazard detection: a pending source is resolved only by a same-cycle forward
   always_comb begin
      rd_data = '0;
      hazard  = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data[i*DATA_WIDTH +: DATA_WIDTH] = read_port(rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
         if (rd_use[i]
             && (rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)
             && pend_q[rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]]
             && !fwd_hit(rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]))
            hazard = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard with and without bypass
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic [1:0]  rd_use;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;

   logic [63:0] rd_data_b, rd_data_n;
   logic        hazard_b, hazard_n;
   logic [31:0] pending_b, pending_n;
   logic [31:0] dbg_b, dbg_n;

   always #5 clk = ~clk;

   regfile_scoreboard #(.BYPASS_EN(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data_b),
      .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .flush(flush), .hazard(hazard_b), .pending(pending_b), .dbg_data(dbg_b)
   );

   regfile_scoreboard #(.BYPASS_EN(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data_n),
      .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .flush(flush), .hazard(hazard_n), .pending(pending_n), .dbg_data(dbg_n)
   );

   typedef struct {
      int          id;
      logic [63:0] rd_b;
      logic [63:0] rd_n;
      logic        hz_b;
      logic        hz_n;
      logic [31:0] pend;
      logic [31:0] dbg_b;
      logic [31:0] dbg_n;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;

   function automatic logic [31:0] model_read(input int a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && wb_en && int'(wb_addr) == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic model_hazard(input bit byp);
      logic h = 1'b0;
      for (int i = 0; i < 2; i++) begin
         int a = int'(rd_addr[i*5 +: 5]);
         bool_check: begin
            if (rd_use[i] && a != 0 && m_pend[a] && !(byp && wb_en && int'(wb_addr) == a))
               h = 1'b1;
         end
      end
      return h;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 32'h0;
         m_pend[r] = 1'b0;
      end
   endtask

   task automatic model_update();
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (flush) begin
         for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
      end else begin
         if (wb_en && wb_addr != 5'd0) m_pend[wb_addr] = 1'b0;
         if (issue_en && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
      end
   endtask

   task automatic push_expect();
      exp_t e;
      e.id = cyc;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         e.rd_b[i*32 +: 32] = model_read(int'(rd_addr[i*5 +: 5]), 1'b1);
         e.rd_n[i*32 +: 32] = model_read(int'(rd_addr[i*5 +: 5]), 1'b0);
      end
      e.hz_b = model_hazard(1'b1);
      e.hz_n = model_hazard(1'b0);
      for (int r = 0; r < 32; r++) e.pend[r] = m_pend[r];
      e.dbg_b = model_read(10, 1'b1);
      e.dbg_n = model_read(10, 1'b0);
      exp_q.push_back(e);
   endtask

   task automatic set_idle();
      rd_addr = '0; rd_use = '0; issue_en = 0; issue_addr = '0;
      wb_en = 0; wb_addr = '0; wb_data = '0; flush = 0;
   endtask

   // inputs are already driven; record expectation, then let the clock edge commit
   task automatic apply_cycle();
      push_expect();
      @(posedge clk);
      model_update();
      #1;
   endtask

   // reset between clock edges; outputs must clear without waiting for a clock
   task automatic reset_pulse();
      rst_n = 1'b0;
      model_clear();
      #1;
      push_expect();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s id=%0d actual=%h expected=%h", name, id, act, exp);
      end
   endtask

   // monitor: outputs are always valid, so every negedge with a queued expectation is compared
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_data_byp",   e.id, rd_data_b,       e.rd_b);
         check("rd_data_nobyp", e.id, rd_data_n,       e.rd_n);
         check("hazard_byp",    e.id, 64'(hazard_b),   64'(e.hz_b));
         check("hazard_nobyp",  e.id, 64'(hazard_n),   64'(e.hz_n));
         check("pending_byp",   e.id, 64'(pending_b),  64'(e.pend));
         check("pending_nobyp", e.id, 64'(pending_n),  64'(e.pend));
         check("dbg_byp",       e.id, 64'(dbg_b),      64'(e.dbg_b));
         check("dbg_nobyp",     e.id, 64'(dbg_n),      64'(e.dbg_n));
      end
   end

   initial begin
      rst_n = 1'b0;
      set_idle();
      reset_pulse();

      // fill every register, then reset mid-run
      for (int r = 1; r < 32; r++) begin
         set_idle(); wb_en = 1; wb_addr = 5'(r); wb_data = $urandom | 32'h1;
         rd_addr = {5'(r - 1), 5'(r)};
         apply_cycle();
      end
      set_idle(); rd_addr = {5'd10, 5'd31}; apply_cycle();
      set_idle(); rd_addr = {5'd10, 5'd31}; reset_pulse();

      // x0 is hardwired and never pending
      set_idle(); wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF; apply_cycle();
      set_idle(); issue_en = 1; issue_addr = 5'd0; apply_cycle();
      set_idle(); rd_use = 2'b11; apply_cycle();

      // bypass on register 5
      set_idle(); wb_en = 1; wb_addr = 5'd5; wb_data = 32'h11; apply_cycle();
      set_idle(); wb_en = 1; wb_addr = 5'd5; wb_data = 32'h22; rd_addr[4:0] = 5'd5; apply_cycle();
      set_idle(); rd_addr[4:0] = 5'd5; apply_cycle();

      // RAW hazard on register 7
      set_idle(); issue_en = 1; issue_addr = 5'd7; apply_cycle();
      set_idle(); rd_use = 2'b10; rd_addr[9:5] = 5'd7; apply_cycle();
      set_idle(); rd_use = 2'b10; rd_addr[9:5] = 5'd7; wb_en = 1; wb_addr = 5'd7; wb_data = 32'h77; apply_cycle();
      set_idle(); rd_use = 2'b10; rd_addr[9:5] = 5'd7; apply_cycle();

      // simultaneous issue and writeback on register 9
      set_idle(); issue_en = 1; issue_addr = 5'd9; apply_cycle();
      set_idle(); issue_en = 1; issue_addr = 5'd9; wb_en = 1; wb_addr = 5'd9; wb_data = 32'h99; apply_cycle();
      set_idle(); rd_use = 2'b01; rd_addr[4:0] = 5'd9; apply_cycle();

      // flush beats a same-cycle issue
      set_idle(); issue_en = 1; issue_addr = 5'd3; apply_cycle();
      set_idle(); issue_en = 1; issue_addr = 5'd4; apply_cycle();
      set_idle(); issue_en = 1; issue_addr = 5'd8; apply_cycle();
      set_idle(); flush = 1; issue_en = 1; issue_addr = 5'd12; rd_use = 2'b11; rd_addr = {5'd4, 5'd3}; apply_cycle();
      set_idle(); rd_use = 2'b11; rd_addr = {5'd12, 5'd8}; apply_cycle();

      // debug tap on register 10
      set_idle(); wb_en = 1; wb_addr = 5'd10; wb_data = 32'hA5A5A5A5; apply_cycle();
      set_idle(); apply_cycle();

      // randomized traffic concentrated on a few registers to provoke collisions
      for (int n = 0; n < 1500; n++) begin
         set_idle();
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse();
         end else begin
            rd_addr[4:0] = 5'($urandom_range(0, 15));
            rd_addr[9:5] = 5'($urandom_range(0, 15));
            rd_use       = 2'($urandom_range(0, 3));
            issue_en     = 1'($urandom_range(0, 1));
            issue_addr   = 5'($urandom_range(0, 15));
            wb_en        = 1'($urandom_range(0, 1));
            wb_addr      = ($urandom_range(0, 3) == 0) ? rd_addr[4:0] : 5'($urandom_range(0, 15));
            wb_data      = $urandom;
            flush        = ($urandom_range(0, 15) == 0);
            apply_cycle();
         end
      end

      set_idle();
      apply_cycle();
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
